// File: rtl/io_bus_pkg.sv
// io_bus_pkg -- shared constants for the IO bus responder.
//   Address map (byte addresses), register offsets from the IO base, and
//   bit positions of the interrupt-pending register.
package io_bus_pkg;

    // Register offsets from the IO base
    localparam logic [31:0] IO_BASE     = 32'h0000_8000;
    localparam logic [31:0] OFF_LED     = 32'h00;
    localparam logic [31:0] OFF_BTN     = 32'h04;
    localparam logic [31:0] OFF_TCOUNT  = 32'h08;
    localparam logic [31:0] OFF_TCMP    = 32'h0C;
    localparam logic [31:0] OFF_IPEND   = 32'h10;
    localparam logic [31:0] OFF_IMASK   = 32'h14;

    // Absolute register addresses
    localparam logic [31:0] ADDR_LED    = IO_BASE + OFF_LED;
    localparam logic [31:0] ADDR_BTN    = IO_BASE + OFF_BTN;
    localparam logic [31:0] ADDR_TCOUNT = IO_BASE + OFF_TCOUNT;
    localparam logic [31:0] ADDR_TCMP   = IO_BASE + OFF_TCMP;
    localparam logic [31:0] ADDR_IPEND  = IO_BASE + OFF_IPEND;
    localparam logic [31:0] ADDR_IMASK  = IO_BASE + OFF_IMASK;

    // Interrupt-pending bit indices
    localparam int NUM_IRQ   = 6;
    localparam int IP_TMR    = 0;
    localparam int IP_BTN0   = 1;
    localparam int IP_CP0TMR = 5;

endpackage

// File: rtl/io_timer.sv
// io_timer -- prescaled 32-bit timer with compare match.
//   Ports: clk, rst (sync, active high); cntWe/cmpWe write strobes with
//   wData; count/cmp register values; match is a one-cycle pulse on the tick
//   where count equals a nonzero compare value (count reloads to 0 then).
module io_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cntWe,
    input  logic        cmpWe,
    input  logic [31:0] wData,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        match
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc;
    logic        tick;

    // A compare write restarts the prescale period, so no tick that cycle.
    assign tick  = (presc == PRE_LAST) && !cmpWe;
    // A CPU count write wins over the tick, including the match reload.
    assign match = tick && !cntWe && (cmp != '0) && (count == cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
            cmp   <= '0;
        end else begin
            if (cmpWe) begin
                cmp   <= wData;
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 16'd1;
            end

            if (cntWe)
                count <= wData;
            else if (match)
                count <= '0;
            else if (tick)
                count <= count + 32'd1;   // natural wrap at 0xFFFF_FFFF
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// io_bus_responder -- data RAM plus memory-mapped IO for a single-cycle CPU.
//   Ports: clk, rst (sync, active high); memCe/memWr/memAddr/wtData/rdData
//   CPU data bus (combinational read); intimer CP0 timer request; btn async
//   buttons; led LED register; intr masked interrupt lines.
//   Build option: define IO_TIMER_EN to include the TCOUNT/TCMP timer;
//   otherwise those registers read 0 and IPEND[0] stays 0.
module io_bus_responder
    import io_bus_pkg::*;
#(
    parameter int RAM_AW       = 8,
    parameter int TMR_PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memCe,
    input  logic                memWr,
    input  logic [31:0]         memAddr,
    input  logic [31:0]         wtData,
    output logic [31:0]         rdData,
    input  logic                intimer,
    input  logic [3:0]          btn,
    output logic [15:0]         led,
    output logic [NUM_IRQ-1:0]  intr
);
    logic [31:0]         ram [0:(1 << RAM_AW) - 1];
    logic [29:0]         wordAddr;
    logic [RAM_AW-1:0]   ramIdx;
    logic                ramHit;
    logic                wrEn;

    logic [NUM_IRQ-1:0]  ipend;
    logic [NUM_IRQ-1:0]  imask;
    logic [NUM_IRQ-1:0]  setMask;
    logic [NUM_IRQ-1:0]  w1cMask;
    logic [3:0]          btnS1, btnS2, btnPrev;
    logic                intimerPrev;

    logic [31:0]         tcount;
    logic [31:0]         tcmp;
    logic                timerMatch;

    logic                unusedAddrBits;
    assign unusedAddrBits = ^memAddr[1:0];

    assign wordAddr = memAddr[31:2];
    assign ramIdx   = memAddr[RAM_AW+1:2];
    assign ramHit   = (memAddr[31:RAM_AW+2] == '0);
    assign wrEn     = memCe && memWr && !rst;

    // RAM is not reset; RAM decode takes precedence over the IO window.
    always_ff @(posedge clk) begin
        if (wrEn && ramHit)
            ram[ramIdx] <= wtData;
    end

    function automatic logic regWe(input logic [31:0] addr);
        return wrEn && !ramHit && (wordAddr == addr[31:2]);
    endfunction

`ifdef IO_TIMER_EN
    logic tcntWe, tcmpWe;
    assign tcntWe = regWe(ADDR_TCOUNT);
    assign tcmpWe = regWe(ADDR_TCMP);

    io_timer #(.PRESCALE(TMR_PRESCALE)) uTimer (
        .clk   (clk),
        .rst   (rst),
        .cntWe (tcntWe),
        .cmpWe (tcmpWe),
        .wData (wtData),
        .count (tcount),
        .cmp   (tcmp),
        .match (timerMatch)
    );
`else
    localparam int unusedPrescale = TMR_PRESCALE;
    assign tcount     = '0;
    assign tcmp       = '0;
    assign timerMatch = 1'b0;
`endif

    always_comb begin
        setMask            = '0;
        setMask[IP_TMR]    = timerMatch;
        setMask[IP_CP0TMR] = intimer && !intimerPrev;
        for (int i = 0; i < 4; i++)
            setMask[IP_BTN0+i] = btnS2[i] && !btnPrev[i];
        w1cMask = regWe(ADDR_IPEND) ? wtData[NUM_IRQ-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led         <= '0;
            imask       <= '0;
            ipend       <= '0;
            btnS1       <= '0;
            btnS2       <= '0;
            btnPrev     <= '0;
            intimerPrev <= 1'b0;
        end else begin
            if (regWe(ADDR_LED))
                led <= wtData[15:0];
            if (regWe(ADDR_IMASK))
                imask <= wtData[NUM_IRQ-1:0];
            btnS1       <= btn;
            btnS2       <= btnS1;
            btnPrev     <= btnS2;
            intimerPrev <= intimer;
            // Set applied after clear: a same-cycle event beats W1C.
            ipend       <= (ipend & ~w1cMask) | setMask;
        end
    end

    assign intr = ipend & imask;

    always_comb begin
        rdData = '0;
        if (memCe && !memWr) begin
            if (ramHit) begin
                rdData = ram[ramIdx];
            end else begin
                case (wordAddr)
                    ADDR_LED[31:2]:    rdData = {16'b0, led};
                    ADDR_BTN[31:2]:    rdData = {28'b0, btnS2};
                    ADDR_TCOUNT[31:2]: rdData = tcount;
                    ADDR_TCMP[31:2]:   rdData = tcmp;
                    ADDR_IPEND[31:2]:  rdData = {{(32-NUM_IRQ){1'b0}}, ipend};
                    ADDR_IMASK[31:2]:  rdData = {{(32-NUM_IRQ){1'b0}}, imask};
                    default:           rdData = '0;
                endcase
            end
        end
    end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, meaning log2 of data-RAM depth in 32-bit words.
REQ-002 SHALL have parameter TMR_PRESCALE, default 1, meaning clk cycles per timer tick (range 1..65535).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port memCe  input  1  CPU data access enable.
REQ-006 SHALL have port memWr  input  1  1 = write, 0 = read; valid only with memCe.
REQ-007 SHALL have port memAddr  input  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have port wtData  input  32  write data.
REQ-009 SHALL have port rdData  output  32  read data returned to the CPU.
REQ-010 SHALL have port intimer  input  1  CP0 timer interrupt request from the CPU.
REQ-011 SHALL have port btn  input  4  asynchronous push-button inputs.
REQ-012 SHALL have port led  output  16  LED register value.
REQ-013 SHALL have port intr  output  6  interrupt lines to the CPU.

Function
REQ-014 SHALL decode: RAM at 0x0000_0000 to 4*2^RAM_AW-1; LED 0x8000; BTN 0x8004 (RO); TCOUNT 0x8008; TCMP 0x800C; IPEND 0x8010 (W1C); IMASK 0x8014 (bits [5:0]).
REQ-015 SHALL drive rdData combinationally in the same cycle when memCe=1 and memWr=0 (zero-latency read for the single-cycle core); rdData=0 otherwise.
REQ-016 SHALL return 0 for unmapped reads and ignore unmapped writes.
REQ-017 SHALL perform writes at the rising edge where memCe=1 and memWr=1; full 32-bit words only.
REQ-018 SHALL pass btn through a 2-flop synchronizer, then set IPEND[1+i] on a synchronized 0->1 edge of btn[i]; BTN read returns the synchronized level.
REQ-019 SHALL set IPEND[5] on a 0->1 edge of intimer.
REQ-020 SHALL advance TCOUNT by 1 every TMR_PRESCALE cycles; when TCMP!=0 and TCOUNT==TCMP on a tick, set IPEND[0] and load TCOUNT=0 on that tick.
REQ-021 SHALL give a CPU write to TCOUNT priority over the tick increment in the same cycle; a TCMP write restarts the prescaler.
REQ-022 SHALL wrap TCOUNT 0xFFFF_FFFF -> 0 without setting IPEND[0] when TCMP==0.
REQ-023 SHALL clear IPEND bits written with 1; a set event and a W1C clear of the same bit in the same cycle SHALL leave the bit set.
REQ-024 SHALL drive intr[k] = IPEND[k] & IMASK[k], combinational from registers.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear LED, TCOUNT, TCMP, prescaler, IPEND, IMASK, synchronizer and edge-detect flops to 0; led=0, intr=0.
REQ-026 SHALL NOT reset RAM contents; reads before first write are undefined.
REQ-027 SHALL ignore bus writes and interrupt events in any cycle with rst=1.

Configuration
REQ-028 SHALL, with IO_TIMER_EN defined, implement TCOUNT/TCMP/prescaler per REQ-020..022.
REQ-029 SHALL, without IO_TIMER_EN, read TCOUNT/TCMP as 0, ignore writes to them, and hold IPEND[0]=0.

Structure
REQ-030 SHALL place address constants, IPEND bit indices (TMR=0, BTN0..3=1..4, CP0TMR=5) and register-offset constants in shared package io_bus_pkg.
REQ-031 SHALL implement the timer as sub-module io_timer (prescaler, count, compare, match pulse), instantiated only under IO_TIMER_EN.

Verification
REQ-032 SHALL verify: write 0xDEADBEEF to 0x0000_0010, read 0x0000_0013 -> rdData=0xDEADBEEF same cycle.
REQ-033 SHALL verify: TMR_PRESCALE=1, TCMP=5, IMASK=0x01 -> IPEND[0] set 6 ticks after TCOUNT write of 0, intr[0]=1; write 0x01 to IPEND -> intr[0]=0 next cycle.
REQ-034 SHALL verify: btn[2] 0->1 -> IPEND[3]=1 on the third edge; intr[3]=1 only when IMASK[3]=1; held btn sets no further edge.
REQ-035 SHALL verify: intimer rises in the same cycle as a W1C of 0x20 -> IPEND[5] remains 1.
REQ-036 SHALL verify: rst asserted mid-timer-count with pending bits set -> TCOUNT=0, IPEND=0, led=0, intr=0 after one edge; RAM data written earlier still reads back.
REQ-037 SHALL verify: build without IO_TIMER_EN, write 0x1234 to TCMP -> reads 0, intr[0] never asserts.
